// File: rtl/otter_io_pkg.sv
// Shared OTTER I/O definitions: button register addresses and the debounce state encoding.
package otter_io_pkg;

    localparam logic [31:0] BTN_LVL_ADDR     = 32'h1100_8004;
    localparam logic [31:0] BTN_PEND_ADDR    = 32'h1100_800C;
    localparam logic [31:0] BTN_MASK_ADDR    = 32'h1100_8010;
    localparam logic [31:0] BTN_CLR_ADDR     = 32'h1100_E000;
    localparam logic [31:0] BTN_MASK_WR_ADDR = 32'h1100_E004;

    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        WAIT_HI = 2'd1,
        ST_HI   = 2'd2,
        WAIT_LO = 2'd3
    } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser followed by a counting debounce FSM.
//   state   | meaning
//   ST_LO   | accepted level low, sync low
//   WAIT_HI | sync high, counting stable high samples
//   ST_HI   | accepted level high, sync high
//   WAIT_LO | sync low, counting stable low samples
module btn_debounce
    import otter_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    db_state_t     state_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          sync_s;

    assign sync_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst_i) begin
            sync_q  <= '0;
            state_q <= ST_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            case (state_q)
                ST_LO: begin
                    if (sync_s) begin
                        state_q <= WAIT_HI;
                        cnt_q   <= CNT_ONE;
                    end
                end
                WAIT_HI: begin
                    if (!sync_s) begin
                        state_q <= ST_LO;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_HI;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_HI: begin
                    if (!sync_s) begin
                        state_q <= WAIT_LO;
                        cnt_q   <= CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    if (sync_s) begin
                        state_q <= ST_HI;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_LO;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_LO;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    // Decoded from current state so the top's pend register sets on the accepting edge.
    assign rise_o  = (state_q == WAIT_HI) && sync_s && (cnt_q == CNT_LAST);
    assign level_o = level_q;

endmodule

// File: rtl/btn_intr_ctrl.sv
// Memory-mapped button front end: debounced levels, rising-edge pending bits,
// interrupt mask and a level interrupt to the MCU.
module btn_intr_ctrl
    import otter_io_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [31:0]      iobus_addr,
    input  logic [31:0]      iobus_out,
    input  logic             iobus_wr,
    output logic [31:0]      rd_data,
    output logic [N_BTN-1:0] btn_db,
    output logic             intr
);

    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] pend_q, pend_d;
    logic [N_BTN-1:0] mask_q, mask_d;
    logic             unused_wdata;

    assign unused_wdata = ^iobus_out;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst_i   (RST),
            .raw_i   (btn_raw[i]),
            .level_o (btn_db[i]),
            .rise_o  (rise[i])
        );
    end

    always_comb begin
        pend_d = pend_q;
        mask_d = mask_q;
        if (iobus_wr && (iobus_addr == BTN_CLR_ADDR)) begin
            pend_d = pend_q & ~iobus_out[N_BTN-1:0];
        end
        if (iobus_wr && (iobus_addr == BTN_MASK_WR_ADDR)) begin
            mask_d = iobus_out[N_BTN-1:0];
        end
        // A new edge beats a simultaneous clear so no press is lost.
        pend_d = pend_d | rise;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            pend_q <= '0;
            mask_q <= '0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (iobus_addr)
            BTN_LVL_ADDR:  rd_data[N_BTN-1:0] = btn_db;
            BTN_PEND_ADDR: rd_data[N_BTN-1:0] = pend_q;
            BTN_MASK_ADDR: rd_data[N_BTN-1:0] = mask_q;
            default:       rd_data = '0;
        endcase
    end

    assign intr = |(pend_q & mask_q);

endmodule

// File: doc/btn_intr_ctrl.md
# btn_intr_ctrl

Memory-mapped button front end for the OTTER I/O bus. It synchronises and debounces the raw board buttons, and latches a pending bit on each debounced rising edge. It raises a level interrupt to the MCU `intr` input until software clears it. It sits between the board button pins and the wrapper's input mux / MCU interrupt, replacing the direct raw-button connections.

## Interface
- `N_BTN`, default 5: number of buttons handled.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable samples required to accept a new level (1 ms at 50 MHz); ≥ 2.
- `clk` input, 1: system clock (50 MHz `s_clk` domain).
- `RST` input, 1: reset. One clock; reset is synchronous and active-high.
- `btn_raw` input, N_BTN: asynchronous raw button pins.
- `iobus_addr` input, 32: MCU I/O address.
- `iobus_out` input, 32: MCU write data.
- `iobus_wr` input, 1: MCU write strobe.
- `rd_data` output, 32: read data for the wrapper input mux; 0 when the address is not decoded.
- `btn_db` output, N_BTN: debounced button levels.
- `intr` output, 1: level interrupt, `|(pend & mask)`.

## Operation
- **Register map.** Bits ≥ N_BTN read 0 and ignore writes.
  - `0x1100_8004`: read, debounced level `btn_db`.
  - `0x1100_800C`: read, `pend`.
  - `0x1100_8010`: read, `mask`.
  - `0x1100_E000`: write, pend clear (W1C): bit i = 1 clears `pend[i]`.
  - `0x1100_E004`: write, `mask`.
- **Writes.** Take effect on the clk edge where `iobus_wr`=1 and the address matches.
- **Reads.** `rd_data` is combinational from `iobus_addr`.
- **Per-button path.**
  - 2-FF synchroniser, then a debounce FSM with one counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - States: `ST_LO`, `WAIT_HI`, `ST_HI`, `WAIT_LO`.
  - `ST_LO`: sync=1 → `WAIT_HI`, cnt=1.
  - `WAIT_HI`:
    - sync=0 → `ST_LO`, cnt=0.
    - sync=1 and cnt=DEBOUNCE_CYCLES-1 → `ST_HI`, and pulse `rise` for one cycle.
    - Otherwise cnt+1.
  - `ST_HI` / `WAIT_LO`: symmetric; no pulse on the falling edge.
  - `btn_db[i]` = 1 in `ST_HI` and `WAIT_LO`.
- **Pending.** `rise[i]` sets `pend[i]` regardless of mask. When set and W1C clear hit the same bit in the same cycle, the set wins.
- **Mask.** `mask` gates `intr` only.
- **Reset values.**
  - All FSMs in `ST_LO`; counters, synchronisers, `pend` and `mask` are 0.
  - Outputs `btn_db`=0 and `intr`=0.
  - `rd_data` follows the address decode of the reset register values.
- **Reset mid-debounce.** Abandons the count. A button held through reset is re-accepted after a full debounce and generates a `rise`.

## Timing
- **Raw rise to `btn_db`.** Raw rises before edge k and stays stable:
  - sync output high after edge k+1;
  - `WAIT_HI` entered on edge k+2;
  - `btn_db`=1 and `pend` set on edge k+1+DEBOUNCE_CYCLES.
- **Interrupt.** `intr` follows on the same edge; it is combinational from registers and glitch-free.
- **Rejected bounce.** Any sync glitch shorter than DEBOUNCE_CYCLES during `WAIT_*` returns to the stable state with no output change.
- **Clear.** A W1C on edge m drops `intr` after edge m, unless another unmasked `pend` bit is set or a `rise` for that bit occurs on edge m.
- **Mask write.** Affects `intr` from the edge of the write.
- **Counter range.** The counter never exceeds DEBOUNCE_CYCLES-1; no wrap.

## Structure
- **Package `otter_io_pkg`** holds:
  - address localparams `BTN_LVL_ADDR`, `BTN_PEND_ADDR`, `BTN_MASK_ADDR`, `BTN_CLR_ADDR`, `BTN_MASK_WR_ADDR`;
  - the `db_state_t` enum for the debounce FSM.
- **Sub-module `btn_debounce`:** synchroniser + FSM + counter, parameterised by DEBOUNCE_CYCLES. Instantiated N_BTN times via generate.
- **Top level** holds `pend`, `mask`, the register decode and `intr`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and N_BTN=5.
- **Reset.** Hold RST 3 cycles with `btn_raw`=5'h1F → `btn_db`=0, `intr`=0, reads of `pend`/`mask` = 0. After release, `btn_db`=5'h1F exactly 5 edges later and `pend`=5'h1F.
- **Bounce rejection.** Write `mask`=5'h01; raw[0] toggles 1,0,1,0 on alternating cycles, then stays 1 → no `btn_db` change during the toggling. `btn_db[0]` and `intr` rise 5 edges after the final 0→1; `pend` read = 5'h01.
- **Falling edge.** After the previous scenario, release raw[0] → `btn_db[0]` falls 5 edges later; `pend` is unchanged and `intr` stays 1.
- **W1C and masking.** Write `0x1100_E000` with 32'h1 → `intr`=0 next cycle. Press raw[2] with `mask`=5'h01 → `pend`=5'h04 and `intr`=0. Then write `mask`=5'h05 → `intr`=1 from that edge.
- **Set/clear collision.** Issue a W1C for bit 1 on the same edge `rise[1]` fires → `pend[1]` stays 1.
- **Decode.** Reads at `0x1100_8000` and `0x1100_8008` → `rd_data`=0. Writes to unrelated addresses → `mask`/`pend` unchanged.
